servant_boot_loader: RTL and testbench



---
 rtl/servant_boot_loader.sv | 101 ++++++++++
 tb/tb_servant_boot_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/servant_boot_loader.sv
// servant_boot_loader: copies a flash image into RAM over SPI READ (0x03) and then releases the CPU from reset.
module servant_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int          WORDS      = 2048,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter int          CLK_DIV    = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rstn,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic        o_flash_SCK,
  output logic        o_flash_CSn,
  output logic        o_flash_MOSI,
  input  logic        i_flash_MISO,
  output logic        o_busy,
  output logic        o_cpu_rst,
  output logic        o_done
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int CW = WORDS > 0 ? $clog2(WORDS + 1) : 1;
  typedef enum logic [2:0] {IDLE, CMD, READ, WRITE, DONE} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [4:0] bits;
  logic [CW-1:0] words;
  logic [31:0] sh;
  logic tick;
  assign tick = div == DW'(CLK_DIV - 1);
  assign o_wb_we = o_wb_cyc;
  assign o_wb_sel = {4{o_wb_cyc}};
  // the shift register holds the word big-endian as received; RAM wants the first byte in the low lane
  assign o_wb_dat = {sh[7:0], sh[15:8], sh[23:16], sh[31:24]};
  always_ff @(posedge wb_clk or negedge wb_rstn)
    if (!wb_rstn) begin
      state <= IDLE;
      div <= '0;
      bits <= '0;
      words <= '0;
      sh <= '0;
      o_wb_adr <= RAM_BASE;
      o_wb_cyc <= 1'b0;
      o_flash_SCK <= 1'b0;
      o_flash_CSn <= 1'b1;
      o_flash_MOSI <= 1'b0;
      o_busy <= 1'b1;
      o_cpu_rst <= 1'b1;
      o_done <= 1'b0;
    end else
      case (state)
        IDLE:
          if (WORDS == 0) begin
            state <= DONE;
            o_busy <= 1'b0;
            o_cpu_rst <= 1'b0;
            o_done <= 1'b1;
          end else begin
            sh <= {8'h03, FLASH_ADDR};
            o_flash_CSn <= 1'b0;
            state <= CMD;
          end
        CMD, READ: begin
          div <= tick ? '0 : div + DW'(1);
          if (tick) begin
            o_flash_SCK <= !o_flash_SCK;
            if (!o_flash_SCK && state == READ) sh <= {sh[30:0], i_flash_MISO};
            if (o_flash_SCK) begin
              bits <= bits + 5'd1;
              if (state == CMD) begin
                sh <= {sh[30:0], 1'b0};
                o_flash_MOSI <= bits != 5'd31 && sh[30];
              end
              if (bits == 5'd31) begin
                state <= state == CMD ? READ : WRITE;
                o_wb_cyc <= state == READ;
              end
            end
          end
        end
        WRITE:
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_adr <= o_wb_adr + 32'd4;
            words <= words + CW'(1);
            if (words + CW'(1) == CW'(WORDS)) begin
              state <= DONE;
              o_flash_CSn <= 1'b1;
              o_busy <= 1'b0;
              o_cpu_rst <= 1'b0;
              o_done <= 1'b1;
            end else
              state <= READ;
          end
        DONE: ;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_servant_boot_loader.sv
// tb_servant_boot_loader: two 4-word loaders (CLK_DIV 2 and 1) plus an empty-image loader against SPI flash and RAM models.
module tb_servant_boot_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rstn = 3'b000;
  logic [1:0] noise = 2'b00;
  logic [7:0] mem [2][64];
  int ack_wait [2] = '{0, 0};
  int tests = 0, fails = 0;
  localparam logic [75:0] RST = {32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // random ack activity while no cycle is requested must be ignored
  always @(negedge clk) noise <= 2'($urandom);

  for (genvar g = 0; g < 2; g++) begin : gl
    localparam int D = 2 - g;
    logic [31:0] adr, dat, cmd, adr_q, dat_q;
    logic [31:0] wa [8], wd [8];
    logic [3:0] sel;
    logic we, cyc, sck, csn, mosi, miso, busy, cpu_rst, done, ack;
    logic sck_q, csn_q, cyc_q, mosi_q;
    int stall, ec, de, viol, nb, rb, nw, gap;
    servant_boot_loader #(.WORDS(4), .CLK_DIV(D)) dut (
      .wb_clk(clk), .wb_rstn(rstn[g]), .o_wb_adr(adr), .o_wb_dat(dat), .o_wb_sel(sel),
      .o_wb_we(we), .o_wb_cyc(cyc), .i_wb_ack(ack), .o_flash_SCK(sck), .o_flash_CSn(csn),
      .o_flash_MOSI(mosi), .i_flash_MISO(miso), .o_busy(busy), .o_cpu_rst(cpu_rst), .o_done(done));
    assign ack = cyc ? stall == ack_wait[g] : noise[g];
    always @(posedge clk)
      if (!rstn[g]) begin
        ec <= 0;
        stall <= 0;
        nw <= 0;
      end else begin
        ec <= ec + 1;
        stall <= (cyc && !ack) ? stall + 1 : 0;
        if (cyc && ack && nw < 8) begin
          wa[nw] <= adr;
          wd[nw] <= dat;
          nw <= nw + 1;
        end
      end
    always @(posedge sck or posedge csn or negedge rstn[g])
      if (!rstn[g]) begin
        cmd <= 0;
        nb <= 0;
      end else if (csn) nb <= 0;
      else if (nb < 32) begin
        cmd <= {cmd[30:0], mosi};
        nb <= nb + 1;
      end
    // flash shifts its next data bit out on each falling SCK once the command is in
    always @(negedge sck or posedge csn)
      if (csn) rb <= 0;
      else if (nb >= 32) begin
        miso <= mem[g][(int'(cmd[23:0] - 24'h100000) + rb / 8) & 63][7 - rb % 8];
        rb <= rb + 1;
      end
    always @(negedge clk) begin
      sck_q <= sck;
      csn_q <= csn;
      cyc_q <= cyc;
      mosi_q <= mosi;
      adr_q <= adr;
      dat_q <= dat;
      if (!rstn[g]) begin
        viol <= 0;
        de <= 0;
        gap <= 0;
      end else begin
        gap <= (sck != sck_q || (csn_q && !csn) || (cyc_q && !cyc)) ? 0 : gap + 1;
        viol <= viol + int'(sck != sck_q && (gap + 1 != D || (cyc && cyc_q)))
                     + int'(sck && mosi != mosi_q)
                     + int'(cyc && (sck || csn))
                     + int'(cyc && cyc_q && (adr != adr_q || dat != dat_q))
                     + int'(done == cpu_rst || done == busy || (done && (!csn || sck || mosi || cyc)))
                     + int'(done && de == 0 && csn_q);
        if (done && de == 0) de <= ec;
      end
    end
  end

  logic [31:0] e_adr, e_dat;
  logic [3:0] e_sel;
  logic e_we, e_cyc, e_sck, e_csn, e_mosi, e_busy, e_cpu_rst, e_done;
  int e_ec, e_de, e_bad;
  servant_boot_loader #(.WORDS(0)) dut_empty (
    .wb_clk(clk), .wb_rstn(rstn[2]), .o_wb_adr(e_adr), .o_wb_dat(e_dat), .o_wb_sel(e_sel),
    .o_wb_we(e_we), .o_wb_cyc(e_cyc), .i_wb_ack(1'b0), .o_flash_SCK(e_sck), .o_flash_CSn(e_csn),
    .o_flash_MOSI(e_mosi), .i_flash_MISO(1'b0), .o_busy(e_busy), .o_cpu_rst(e_cpu_rst), .o_done(e_done));
  always @(posedge clk) e_ec <= rstn[2] ? e_ec + 1 : 0;
  always @(negedge clk)
    if (!rstn[2]) begin
      e_de <= 0;
      e_bad <= 0;
    end else begin
      e_bad <= e_bad + int'(!e_csn || e_cyc);
      if (e_done && e_de == 0) e_de <= e_ec;
    end

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resets(input string tag);
    chk({tag, "0"}, {gl[0].adr, gl[0].dat, gl[0].sel, gl[0].we, gl[0].cyc, gl[0].sck, gl[0].csn,
                     gl[0].mosi, gl[0].busy, gl[0].cpu_rst, gl[0].done}, RST);
    chk({tag, "1"}, {gl[1].adr, gl[1].dat, gl[1].sel, gl[1].we, gl[1].cyc, gl[1].sck, gl[1].csn,
                     gl[1].mosi, gl[1].busy, gl[1].cpu_rst, gl[1].done}, RST);
    chk({tag, "e"}, {e_adr, e_dat, e_sel, e_we, e_cyc, e_sck, e_csn, e_mosi, e_busy, e_cpu_rst, e_done}, RST);
  endtask

  task automatic check_run(input int g, input logic [31:0] cmd, input int nw, input logic [31:0] wa [8],
                           input logic [31:0] wd [8], input int de, input int viol);
    int d = 2 - g;
    chk($sformatf("cmd%0d", g), 76'(cmd), 76'(32'h0310_0000));
    chk($sformatf("nwrites%0d", g), 76'(nw), 76'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("adr%0d_%0d", g, i), 76'(wa[i]), 76'(4 * i));
      chk($sformatf("dat%0d_%0d", g, i), 76'(wd[i]),
          76'({mem[g][4 * i + 3], mem[g][4 * i + 2], mem[g][4 * i + 1], mem[g][4 * i]}));
    end
    chk($sformatf("done_cycle%0d", g), 76'(de), 76'(1 + 64 * d + 4 * (64 * d + 1 + ack_wait[g])));
    chk($sformatf("protocol%0d", g), 76'(viol), 76'(0));
  endtask

  task automatic wait_all();
    for (int i = 0; i < 3000 && !(gl[0].de != 0 && gl[1].de != 0 && e_de != 0); i++) @(negedge clk);
    chk("timeout", 76'(gl[0].de != 0 && gl[1].de != 0 && e_de != 0), 76'(1));
  endtask

  task automatic check_all();
    check_run(0, gl[0].cmd, gl[0].nw, gl[0].wa, gl[0].wd, gl[0].de, gl[0].viol);
    check_run(1, gl[1].cmd, gl[1].nw, gl[1].wa, gl[1].wd, gl[1].de, gl[1].viol);
    chk("empty_done_cycle", 76'(e_de), 76'(1));
    chk("empty_bus_idle", 76'(e_bad), 76'(0));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[0][i] = 8'(i);
      mem[1][i] = 8'(i);
    end
    repeat (3) @(negedge clk);
    check_resets("rst_init");
    rstn = 3'b111;
    wait_all();
    check_all();
    @(negedge clk);
    #3 rstn = 3'b000;
    #1 check_resets("rst_async_done");
    for (int i = 0; i < 64; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = 8'($urandom);
    end
    ack_wait[0] = 5;
    ack_wait[1] = int'($urandom_range(0, 3));
    repeat (2) @(negedge clk);
    rstn = 3'b111;
    wait_all();
    check_all();
    @(negedge clk);
    rstn = 3'b000;
    for (int i = 0; i < 64; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = 8'($urandom);
    end
    ack_wait[0] = 0;
    ack_wait[1] = int'($urandom_range(0, 3));
    repeat (2) @(negedge clk);
    rstn = 3'b111;
    for (int i = 0; i < 2000 && gl[0].nw < 1; i++) @(negedge clk);
    chk("first_word_written", 76'(gl[0].nw >= 1), 76'(1));
    repeat ($urandom_range(10, 100)) @(negedge clk);
    #3 rstn[0] = 1'b0;
    #1 chk("rst_async_midload", {gl[0].adr, gl[0].dat, gl[0].sel, gl[0].we, gl[0].cyc, gl[0].sck, gl[0].csn,
                                 gl[0].mosi, gl[0].busy, gl[0].cpu_rst, gl[0].done}, RST);
    repeat (2) @(negedge clk);
    rstn[0] = 1'b1;
    wait_all();
    check_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
